// File: rtl/fifo_uart_tx_pkg.sv
// Shared state encoding and line-level constants for the FIFO-draining UART transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the final cycle of each period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic bit_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  assign bit_done = (cnt_r == LAST_CNT);

  // Period counter; wraps on the last cycle so back-to-back periods need no clear.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt_r <= '0;
    end else if (bit_done) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO and serialises each word as a UART frame (start, data LSB first,
// optional parity, one stop bit), chaining frames with no idle gap while words remain.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_r_inc,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  tx_state_t             state_r, state_s;
  logic [DATA_WIDTH-1:0] shift_r, shift_s;
  logic [BW-1:0]         bit_cnt_r, bit_cnt_s;
  logic                  par_en_r, par_en_s;
  logic                  par_bit_r, par_bit_s;
  logic                  tx_s, busy_s, load_s, bit_done_s, timer_clr_s;

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
    even_parity = ^d;
  endfunction

  assign timer_clr_s = (state_r == IDLE);
  assign fifo_r_inc  = load_s;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (timer_clr_s),
    .bit_done (bit_done_s)
  );

  // Load decision: a pop is only legal in IDLE or on the final stop cycle, never during reset.
  always_comb begin
    load_s = 1'b0;
    if (RST) begin
      load_s = 1'b0;
    end else if (state_r == IDLE) begin
      load_s = !fifo_empty;
    end else if ((state_r == STOP) && bit_done_s) begin
      load_s = !fifo_empty;
    end else begin
      load_s = 1'b0;
    end
  end

  // Next-state, next shift/config values and the line level they imply.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    par_en_s  = par_en_r;
    par_bit_s = par_bit_r;
    if (load_s) begin
      state_s   = START;
      shift_s   = fifo_rd_data;
      bit_cnt_s = '0;
      par_en_s  = par_en;
      par_bit_s = (par_typ == PAR_ODD) ? ~even_parity(fifo_rd_data) : even_parity(fifo_rd_data);
    end else begin
      case (state_r)
        IDLE:   state_s = IDLE;
        START: begin
          if (bit_done_s) state_s = DATA;
          else            state_s = START;
        end
        DATA: begin
          if (bit_done_s) begin
            shift_s = shift_r >> 1;
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_s = '0;
              state_s   = par_en_r ? PARITY : STOP;
            end else begin
              bit_cnt_s = bit_cnt_r + BW'(1);
            end
          end else begin
            state_s = DATA;
          end
        end
        PARITY: begin
          if (bit_done_s) state_s = STOP;
          else            state_s = PARITY;
        end
        STOP: begin
          if (bit_done_s) state_s = IDLE;
          else            state_s = STOP;
        end
        default: state_s = IDLE;
      endcase
    end

    case (state_s)
      START:   tx_s = START_BIT;
      DATA:    tx_s = shift_s[0];
      PARITY:  tx_s = par_bit_s;
      STOP:    tx_s = LINE_IDLE;
      IDLE:    tx_s = LINE_IDLE;
      default: tx_s = LINE_IDLE;
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset aborts any frame and drops the popped word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      bit_cnt_r <= '0;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      tx_out    <= LINE_IDLE;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      par_en_r  <= par_en_s;
      par_bit_r <= par_bit_s;
      tx_out    <= tx_s;
      busy      <= busy_s;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx: a queue-backed FIFO plus a per-cycle expected-line model.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_r_inc;
  logic          par_en = 1'b0;
  logic          par_typ = 1'b0;
  logic          tx_out;
  logic          busy;

  always #5 CLK = ~CLK;

  fifo_uart_tx #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .fifo_rd_data(fifo_rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_r_inc  (fifo_r_inc),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .tx_out      (tx_out),
    .busy        (busy)
  );

  logic [DW-1:0] fifo_q[$];
  logic [1:0]    exp_line[$];   // per-cycle {busy, tx_out} still owed by the current frame
  logic          cfg_pe = 1'b0;
  logic          cfg_pt = 1'b0;
  logic          last_inc = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_pops = 0;
  int            p0;
  logic          got;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line for one frame: every bit held CPB cycles, busy high throughout.
  task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
    int   ones;
    logic pbit;
    for (int k = 0; k < CPB; k++) exp_line.push_back(2'b10);
    for (int i = 0; i < DW; i++)
      for (int k = 0; k < CPB; k++) exp_line.push_back({1'b1, d[i]});
    if (pe) begin
      ones = $countones(d);
      pbit = (ones % 2 == 1) ? ~pt : pt;
      for (int k = 0; k < CPB; k++) exp_line.push_back({1'b1, pbit});
    end
    for (int k = 0; k < CPB; k++) exp_line.push_back(2'b11);
  endtask

  task automatic tick(input logic rst_in);
    logic [1:0]    cur;
    logic [DW-1:0] dropped;
    logic          exp_pop;
    @(posedge CLK);
    #1;
    if (last_inc) n_pops++;
    if (last_inc && fifo_q.size() > 0) dropped = fifo_q.pop_front();
    cur = (exp_line.size() > 0) ? exp_line.pop_front() : 2'b01;
    check_val("busy", {31'd0, busy}, {31'd0, cur[1]});
    check_val("tx_out", {31'd0, tx_out}, {31'd0, cur[0]});
    RST     = rst_in;
    par_en  = cfg_pe;
    par_typ = cfg_pt;
    if (rst_in) exp_line.delete();
    if (fifo_q.size() > 0) begin
      fifo_rd_data = fifo_q[0];
      fifo_empty   = 1'b0;
    end else begin
      fifo_rd_data = DW'($urandom);
      fifo_empty   = 1'b1;
    end
    #1;
    exp_pop = !rst_in && (fifo_q.size() > 0) && (exp_line.size() == 0);
    check_val("fifo_r_inc", {31'd0, fifo_r_inc}, {31'd0, exp_pop});
    if (exp_pop) push_frame(fifo_q[0], cfg_pe, cfg_pt);
    last_inc = fifo_r_inc;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (exp_line.size() == 0 && fifo_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick(1'b0);
    end
    if (!done) check_val("drain_timeout", 32'd1, 32'd0);
    tick(1'b0);
  endtask

  task automatic wait_pop(output logic seen);
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick(1'b0);
      if (last_inc) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_val("pop_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset, then a long idle stretch with an empty FIFO.
    tick(1'b1);
    tick(1'b1);
    for (int i = 0; i < 20; i++) tick(1'b0);
    check_val("idle_pops", n_pops, 32'd0);

    // Single word, no parity.
    p0 = n_pops;
    cfg_pe = 1'b0;
    fifo_q.push_back(8'hA5);
    drain();
    check_val("single_pops", n_pops - p0, 32'd1);

    // Parity variants.
    cfg_pe = 1'b1; cfg_pt = 1'b0; fifo_q.push_back(8'hA5); drain();
    cfg_pe = 1'b1; cfg_pt = 1'b1; fifo_q.push_back(8'hA5); drain();
    cfg_pe = 1'b1; cfg_pt = 1'b0; fifo_q.push_back(8'h01); drain();

    // Back-to-back frames.
    p0 = n_pops;
    cfg_pe = 1'b0;
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'hC3);
    drain();
    check_val("b2b_pops", n_pops - p0, 32'd2);

    // Reset during data bit 3; the aborted word must not come back.
    p0 = n_pops;
    fifo_q.push_back(8'h5A);
    fifo_q.push_back(8'h96);
    wait_pop(got);
    for (int i = 0; i < 17; i++) tick(1'b0);
    tick(1'b1);
    drain();
    check_val("reset_pops", n_pops - p0, 32'd2);

    // Parity enable changed mid-frame applies only to the next frame.
    cfg_pe = 1'b0;
    fifo_q.push_back(8'h81);
    wait_pop(got);
    for (int i = 0; i < 10; i++) tick(1'b0);
    cfg_pe = 1'b1;
    fifo_q.push_back(8'h7E);
    drain();

    // Random traffic, configuration churn and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0 && fifo_q.size() < 4) fifo_q.push_back(DW'($urandom));
      if ($urandom_range(0, 19) == 0) cfg_pe = ~cfg_pe;
      if ($urandom_range(0, 19) == 0) cfg_pt = ~cfg_pt;
      tick($urandom_range(0, 699) == 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the async FIFO. It runs entirely in the FIFO read-clock domain.
- Pops one word when the FIFO is non-empty and serialises it as a UART frame: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
- Frames go out back-to-back while data remains. The line idles high when the FIFO is empty.
- This is the drain end of the register-file-to-UART path.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must match the FIFO DATA_WIDTH.
- CLKS_PER_BIT, 8, CLK cycles per UART bit; legal range 2..255.

Ports:
- CLK  in  1  read-domain clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data; show-ahead, valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag, already synchronised to CLK.
- fifo_r_inc  out  1  single-cycle pop strobe to the FIFO read port.
- par_en  in  1  1 = append parity bit; sampled at frame load.
- par_typ  in  1  0 = even, 1 = odd; sampled at frame load.
- tx_out  out  1  serial line, registered, idle high.
- busy  out  1  high from the cycle after load until the stop bit completes.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - Next cycle: state=IDLE, tx_out=1, busy=0, fifo_r_inc=0, bit/cycle counters=0, shift register=0.
  - Reset mid-frame aborts immediately. The popped word is discarded, not re-read.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - Every non-IDLE state lasts exactly CLKS_PER_BIT cycles, counted by a cycle counter running 0..CLKS_PER_BIT-1.
- Load event, in IDLE when fifo_empty=0:
  - fifo_r_inc=1 (combinational in that cycle).
  - Latch fifo_rd_data into the shift register.
  - Latch par_en/par_typ and compute parity: even = XOR of the data bits; odd = its inverse.
  - Next state START.
- Load latency: load at cycle N -> tx_out=0 and busy=1 from cycle N+1.
- START: tx_out=0, then DATA.
- DATA:
  - tx_out = current shift LSB.
  - Shift right at the end of each bit period.
  - After DATA_WIDTH bits go to PARITY if the latched par_en=1, else STOP.
- PARITY: tx_out = latched parity bit, then STOP.
- STOP: tx_out=1. On the last cycle of the stop period:
  - fifo_empty=0: perform the load event in that same cycle. Next state START, busy stays 1, no idle gap.
  - fifo_empty=1: next state IDLE, busy=0.
- Frame length: (DATA_WIDTH+2+par_en)*CLKS_PER_BIT cycles.
- fifo_r_inc:
  - Never asserted outside a load event.
  - Never asserted while fifo_empty=1.
  - At most one pulse per frame.
- Config changes mid-frame have no effect until the next load.
- fifo_empty toggling mid-frame is ignored. It is only evaluated in IDLE and on the last STOP cycle.
- All counters saturate-free. The bit counter width is clog2(DATA_WIDTH+1) and wraps only through FSM reload.

Decomposition:
- Package fifo_uart_tx_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - PAR_EVEN=1'b0 and PAR_ODD=1'b1.
  - Localparams LINE_IDLE=1'b1 and START_BIT=1'b0.
- Sub-module uart_bit_timer:
  - Cycle counter with a synchronous clear.
  - Outputs a bit_done pulse on count CLKS_PER_BIT-1.
  - Shared with the future RX block.

Test Plan (CLKS_PER_BIT=4, DATA_WIDTH=8):
1. Reset with fifo_empty=1 for 20 cycles -> tx_out=1, busy=0, fifo_r_inc never asserted.
2. Single word, no parity: fifo_rd_data=0xA5, empty falls at cycle N.
   - fifo_r_inc=1 only at N.
   - Line from N+1: 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit 4 cycles. 40 cycles total.
   - busy=0 at N+41.
3. Parity: 0xA5 with even parity -> parity bit 0. 0xA5 with odd parity -> 1. 0x01 with even parity -> 1. Each frame is 44 cycles.
4. Back-to-back: FIFO holds 0x3C, 0xC3.
   - Second fifo_r_inc falls on the last stop cycle of frame 1.
   - Frame 2 start bit begins the next cycle; busy never drops between frames.
   - Exactly 2 pops.
5. Mid-frame reset: RST=1 during DATA bit 3 -> next cycle tx_out=1, busy=0.
   - With FIFO non-empty after reset release, a fresh frame starts with the next word. The aborted word is not resent.
6. Config change: par_en toggled 0->1 during DATA -> current frame has no parity bit; the next frame has one.
